// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, operands registered onto the ALU, result captured and
// returned on a per-requester valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational
// EXEC  | operand registers drive the ALU; result captured at cycle end
// RESP  | response valid to owner, held until owner accepts
module alu_share_arbiter #(
  parameter int unsigned       XLEN   = 32,
  parameter int unsigned       OP_W   = 4,
  parameter logic [OP_W-1:0]   OP_MAX = 4'b1010
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_0_i,
  output logic            req_ready_0_o,
  input  logic [OP_W-1:0] req_op_0_i,
  input  logic [XLEN-1:0] req_a_0_i,
  input  logic [XLEN-1:0] req_b_0_i,
  output logic            resp_valid_0_o,
  input  logic            resp_ready_0_i,
  output logic [XLEN-1:0] resp_data_0_o,
  output logic            resp_err_0_o,
  input  logic            req_valid_1_i,
  output logic            req_ready_1_o,
  input  logic [OP_W-1:0] req_op_1_i,
  input  logic [XLEN-1:0] req_a_1_i,
  input  logic [XLEN-1:0] req_b_1_i,
  output logic            resp_valid_1_o,
  input  logic            resp_ready_1_i,
  output logic [XLEN-1:0] resp_data_1_o,
  output logic            resp_err_1_o,
  output logic [XLEN-1:0] alu1_o,
  output logic [XLEN-1:0] alu2_o,
  output logic [OP_W-1:0] alu_op_o,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic            ptr_q;
  logic            owner_q;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] result_q;
  logic            err_q;
  logic            resp_valid_0_q;
  logic            resp_valid_1_q;
  logic            busy_q;

  logic            gnt_valid;
  logic            gnt_id;
  logic            owner_ready;

  // Grant selection: pointer breaks ties, a lone requester always wins.
  always_comb begin
    gnt_valid = req_valid_0_i | req_valid_1_i;
    gnt_id    = (req_valid_0_i && req_valid_1_i) ? ptr_q : req_valid_1_i;
    owner_ready = owner_q ? resp_ready_1_i : resp_ready_0_i;
  end

  assign req_ready_0_o  = (state_q == IDLE) && gnt_valid && !gnt_id;
  assign req_ready_1_o  = (state_q == IDLE) && gnt_valid &&  gnt_id;
  assign resp_valid_0_o = resp_valid_0_q;
  assign resp_valid_1_o = resp_valid_1_q;
  assign resp_data_0_o  = result_q;
  assign resp_data_1_o  = result_q;
  assign resp_err_0_o   = err_q;
  assign resp_err_1_o   = err_q;
  assign alu1_o         = a_q;
  assign alu2_o         = b_q;
  assign alu_op_o       = op_q;
  assign busy_o         = busy_q;

  // Sequencer: latch grant, capture ALU result, hold response until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      ptr_q          <= 1'b0;
      owner_q        <= 1'b0;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      err_q          <= 1'b0;
      resp_valid_0_q <= 1'b0;
      resp_valid_1_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_id;
            op_q    <= gnt_id ? req_op_1_i : req_op_0_i;
            a_q     <= gnt_id ? req_a_1_i  : req_a_0_i;
            b_q     <= gnt_id ? req_b_1_i  : req_b_0_i;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q       <= alu_result_i;
          err_q          <= (op_q > OP_MAX);
          resp_valid_0_q <= !owner_q;
          resp_valid_1_q <= owner_q;
          state_q        <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            resp_valid_0_q <= 1'b0;
            resp_valid_1_q <= 1'b0;
            busy_q         <= 1'b0;
            ptr_q          <= !owner_q;
            state_q        <= IDLE;
          end
        end
        default: begin
          resp_valid_0_q <= 1'b0;
          resp_valid_1_q <= 1'b0;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU stub.
module tb_alu_share_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_0_i, req_ready_0_o, resp_valid_0_o, resp_ready_0_i, resp_err_0_o;
  logic        req_valid_1_i, req_ready_1_o, resp_valid_1_o, resp_ready_1_i, resp_err_1_o;
  logic [3:0]  req_op_0_i, req_op_1_i, alu_op_o;
  logic [31:0] req_a_0_i, req_b_0_i, req_a_1_i, req_b_1_i;
  logic [31:0] resp_data_0_o, resp_data_1_o, alu1_o, alu2_o, alu_result_i;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  alu_share_arbiter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_0_i  (req_valid_0_i),
    .req_ready_0_o  (req_ready_0_o),
    .req_op_0_i     (req_op_0_i),
    .req_a_0_i      (req_a_0_i),
    .req_b_0_i      (req_b_0_i),
    .resp_valid_0_o (resp_valid_0_o),
    .resp_ready_0_i (resp_ready_0_i),
    .resp_data_0_o  (resp_data_0_o),
    .resp_err_0_o   (resp_err_0_o),
    .req_valid_1_i  (req_valid_1_i),
    .req_ready_1_o  (req_ready_1_o),
    .req_op_1_i     (req_op_1_i),
    .req_a_1_i      (req_a_1_i),
    .req_b_1_i      (req_b_1_i),
    .resp_valid_1_o (resp_valid_1_o),
    .resp_ready_1_i (resp_ready_1_i),
    .resp_data_1_o  (resp_data_1_o),
    .resp_err_1_o   (resp_err_1_o),
    .alu1_o         (alu1_o),
    .alu2_o         (alu2_o),
    .alu_op_o       (alu_op_o),
    .alu_result_i   (alu_result_i),
    .busy_o         (busy_o)
  );

  // ALU stub: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND LUI, 0xDEADBEEF otherwise
  always_comb begin
    alu_result_i = 32'hDEADBEEF;
    case (alu_op_o)
      4'd0:  alu_result_i = alu1_o + alu2_o;
      4'd1:  alu_result_i = alu1_o - alu2_o;
      4'd2:  alu_result_i = alu1_o << alu2_o[4:0];
      4'd3:  alu_result_i = {31'd0, $signed(alu1_o) < $signed(alu2_o)};
      4'd4:  alu_result_i = {31'd0, alu1_o < alu2_o};
      4'd5:  alu_result_i = alu1_o ^ alu2_o;
      4'd6:  alu_result_i = alu1_o >> alu2_o[4:0];
      4'd7:  alu_result_i = $unsigned($signed(alu1_o) >>> alu2_o[4:0]);
      4'd8:  alu_result_i = alu1_o | alu2_o;
      4'd9:  alu_result_i = alu1_o & alu2_o;
      4'd10: alu_result_i = alu2_o;
      default: alu_result_i = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction for requester k, inputs already presented in IDLE.
  task automatic serve(input string tag, input logic k, input logic [31:0] d, input logic e);
    #1;
    chk({tag, ".rdy0"}, {31'd0, req_ready_0_o}, {31'd0, !k});
    chk({tag, ".rdy1"}, {31'd0, req_ready_1_o}, {31'd0, k});
    cyc();
    chk({tag, ".exec_rdy"}, {30'd0, req_ready_1_o, req_ready_0_o}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy_o}, 32'd1);
    cyc();
    chk({tag, ".rv"}, {30'd0, resp_valid_1_o, resp_valid_0_o}, k ? 32'd2 : 32'd1);
    chk({tag, ".data"}, k ? resp_data_1_o : resp_data_0_o, d);
    chk({tag, ".err"}, {31'd0, k ? resp_err_1_o : resp_err_0_o}, {31'd0, e});
    if (k) resp_ready_1_i = 1'b1; else resp_ready_0_i = 1'b1;
    cyc();
    resp_ready_0_i = 1'b0;
    resp_ready_1_i = 1'b0;
    chk({tag, ".done"}, {29'd0, busy_o, resp_valid_1_o, resp_valid_0_o}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, ".rv"}, {30'd0, resp_valid_1_o, resp_valid_0_o}, 32'd0);
    chk({tag, ".data0"}, resp_data_0_o, 32'd0);
    chk({tag, ".data1"}, resp_data_1_o, 32'd0);
    chk({tag, ".err"}, {30'd0, resp_err_1_o, resp_err_0_o}, 32'd0);
    chk({tag, ".alu1"}, alu1_o, 32'd0);
    chk({tag, ".alu2"}, alu2_o, 32'd0);
    chk({tag, ".aluop"}, {28'd0, alu_op_o}, 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_0_i = 0; req_op_0_i = 0; req_a_0_i = 0; req_b_0_i = 0; resp_ready_0_i = 0;
    req_valid_1_i = 0; req_op_1_i = 0; req_a_1_i = 0; req_b_1_i = 0; resp_ready_1_i = 0;
    #12;
    check_reset_outputs("rst");
    chk("rst.rdy", {30'd0, req_ready_1_o, req_ready_0_o}, 32'd0);
    rst_ni = 1'b1;
    cyc();

    // single ADD 5+7
    req_valid_0_i = 1; req_op_0_i = 4'd0; req_a_0_i = 5; req_b_0_i = 7;
    #1;
    chk("add.rdy0", {31'd0, req_ready_0_o}, 32'd1);
    chk("add.rdy1", {31'd0, req_ready_1_o}, 32'd0);
    cyc();
    req_valid_0_i = 0;
    chk("add.alu1", alu1_o, 32'd5);
    chk("add.alu2", alu2_o, 32'd7);
    chk("add.aluop", {28'd0, alu_op_o}, 32'd0);
    chk("add.rv_exec", {31'd0, resp_valid_0_o}, 32'd0);
    cyc();
    chk("add.rv0", {31'd0, resp_valid_0_o}, 32'd1);
    chk("add.rv1", {31'd0, resp_valid_1_o}, 32'd0);
    chk("add.data", resp_data_0_o, 32'd12);
    chk("add.err", {31'd0, resp_err_0_o}, 32'd0);
    resp_ready_0_i = 1;
    cyc();
    resp_ready_0_i = 0;
    chk("add.idle", {30'd0, busy_o, resp_valid_0_o}, 32'd0);

    // reset so the pointer starts at 0 for the contention test
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    cyc();

    // simultaneous SUB / SLL, both held valid: grants alternate 0,1,0,1
    req_valid_0_i = 1; req_op_0_i = 4'd1; req_a_0_i = 10; req_b_0_i = 3;
    req_valid_1_i = 1; req_op_1_i = 4'd2; req_a_1_i = 1;  req_b_1_i = 4;
    serve("rr0", 1'b0, 32'd7, 1'b0);
    serve("rr1", 1'b1, 32'd16, 1'b0);
    serve("rr2", 1'b0, 32'd7, 1'b0);
    serve("rr3", 1'b1, 32'd16, 1'b0);
    req_valid_0_i = 0; req_valid_1_i = 0;
    cyc();

    // backpressure on requester 1, requester 0 waits
    req_valid_1_i = 1; req_op_1_i = 4'd7; req_a_1_i = 32'h8000_0000; req_b_1_i = 4;
    #1;
    chk("bp.rdy1", {31'd0, req_ready_1_o}, 32'd1);
    cyc();
    req_valid_1_i = 0;
    req_valid_0_i = 1; req_op_0_i = 4'd0; req_a_0_i = 1; req_b_0_i = 1;
    #1;
    chk("bp.exec_rdy0", {31'd0, req_ready_0_o}, 32'd0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp.rv1_%0d", i), {31'd0, resp_valid_1_o}, 32'd1);
      chk($sformatf("bp.data_%0d", i), resp_data_1_o, 32'hF800_0000);
      chk($sformatf("bp.rdy0_%0d", i), {31'd0, req_ready_0_o}, 32'd0);
      chk($sformatf("bp.rv0_%0d", i), {31'd0, resp_valid_0_o}, 32'd0);
      if (i == 5) resp_ready_1_i = 1;
      cyc();
    end
    resp_ready_1_i = 0;
    chk("bp.rv1_end", {31'd0, resp_valid_1_o}, 32'd0);
    serve("bp.add", 1'b0, 32'd2, 1'b0);

    // SLT vs SLTU sign handling
    req_op_0_i = 4'd3; req_a_0_i = 32'hFFFF_FFFF; req_b_0_i = 1;
    serve("slt", 1'b0, 32'd1, 1'b0);
    req_op_0_i = 4'd4;
    serve("sltu", 1'b0, 32'd0, 1'b0);

    // illegal op
    req_op_0_i = 4'hF; req_a_0_i = 1; req_b_0_i = 2;
    serve("ill", 1'b0, 32'hDEAD_BEEF, 1'b1);
    req_valid_0_i = 0;
    cyc();

    // reset during EXEC (pointer is 1 at this point)
    req_valid_1_i = 1; req_op_1_i = 4'd0; req_a_1_i = 3; req_b_1_i = 4;
    #1;
    chk("mid.rdy1", {31'd0, req_ready_1_o}, 32'd1);
    cyc();
    req_valid_1_i = 0;
    chk("mid.alu1", alu1_o, 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid");
    cyc();
    rst_ni = 1'b1;
    cyc();
    cyc();
    chk("mid.post_rv", {29'd0, busy_o, resp_valid_1_o, resp_valid_0_o}, 32'd0);

    // both valid after reset: pointer back at 0, then LUI clears err
    req_valid_0_i = 1; req_op_0_i = 4'd10; req_a_0_i = 0; req_b_0_i = 32'h1234_5000;
    req_valid_1_i = 1; req_op_1_i = 4'd0;  req_a_1_i = 3; req_b_1_i = 4;
    serve("lui", 1'b0, 32'h1234_5000, 1'b0);
    req_valid_0_i = 0;
    serve("post1", 1'b1, 32'd7, 1'b0);
    req_valid_1_i = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
